// File: rtl/branch_predict_resolve_unit.sv
// Branch unit: 2-bit counter prediction at fetch, resolution and training in EX,
// registered mispredict/redirect pulse and saturating branch statistics.
module branch_predict_resolve_unit #(
    parameter int         N         = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      fetch_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic [N-1:0]      ex_instruction,
    input  logic [N-1:0]      ex_pc,
    input  logic [N-1:0]      ex_target,
    input  logic              ex_pred_taken,
    input  logic              ZFlag,
    input  logic              SFlag,
    input  logic              VFlag,
    input  logic              CFlag,
    output logic              branch_taken,
    output logic              mispredict,
    output logic [N-1:0]      redirect_pc,
    output logic              illegal_br,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);
    localparam int IDX = $clog2(BHT_DEPTH);

    logic [1:0]     bht [BHT_DEPTH];
    logic [IDX-1:0] fidx;
    logic [IDX-1:0] eidx;
    logic [2:0]     funct3;
    logic           is_br;
    logic           cond;
    logic           bad_f3;
    logic           legal;
    logic           wrong;
    logic           unused_bits;

    assign fidx       = fetch_pc[IDX+1:2];
    assign eidx       = ex_pc[IDX+1:2];
    assign funct3     = ex_instruction[14:12];
    assign pred_taken = bht[fidx][1];

    assign unused_bits = ^{fetch_pc[N-1:IDX+2], fetch_pc[1:0],
                           ex_instruction[N-1:15], ex_instruction[11:7]};

    assign is_br = ex_valid && (ex_instruction[6:0] == 7'b1100011);

    always_comb begin
        cond   = 1'b0;
        bad_f3 = 1'b0;
        case (funct3)
            3'b000:  cond = ZFlag;
            3'b001:  cond = ~ZFlag;
            3'b100:  cond = SFlag ^ VFlag;
            3'b101:  cond = ~(SFlag ^ VFlag);
            3'b110:  cond = ~CFlag;
            3'b111:  cond = CFlag;
            default: bad_f3 = 1'b1;
        endcase
    end

    assign legal        = is_br && !bad_f3;
    assign branch_taken = legal && cond;
    assign wrong        = legal && (branch_taken != ex_pred_taken);

    // Write-only-on-edge table: a same-cycle fetch read sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
        end else if (legal) begin
            if (branch_taken && bht[eidx] != 2'b11)
                bht[eidx] <= bht[eidx] + 2'd1;
            else if (!branch_taken && bht[eidx] != 2'b00)
                bht[eidx] <= bht[eidx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict       <= 1'b0;
            illegal_br       <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= wrong;
            illegal_br <= is_br && bad_f3;
            if (wrong)
                redirect_pc <= branch_taken ? ex_target : ex_pc + N'(4);
            if (legal && branch_count != '1)
                branch_count <= branch_count + 1'b1;
            if (wrong && mispredict_count != '1)
                mispredict_count <= mispredict_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Scoreboard bench: driver queues expected registered outputs per cycle,
// a negedge monitor pops and compares them.
module tb_branch_predict_resolve_unit;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   fetch_pc = '0;
    logic          pred_taken;
    logic          ex_valid = 1'b0;
    logic [31:0]   ex_instruction = '0;
    logic [31:0]   ex_pc = '0;
    logic [31:0]   ex_target = '0;
    logic          ex_pred_taken = 1'b0;
    logic          ZFlag = 1'b0, SFlag = 1'b0, VFlag = 1'b0, CFlag = 1'b0;
    logic          branch_taken;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic          illegal_br;
    logic [SW-1:0] branch_count;
    logic [SW-1:0] mispredict_count;

    branch_predict_resolve_unit #(
        .N(32), .BHT_DEPTH(64), .CTR_INIT(2'b01), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_instruction(ex_instruction), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ZFlag(ZFlag), .SFlag(SFlag), .VFlag(VFlag), .CFlag(CFlag),
        .branch_taken(branch_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .illegal_br(illegal_br),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] BILL = 32'h0000_2063;
    localparam logic [31:0] BLT  = 32'h0000_4063;
    localparam logic [31:0] BGE  = 32'h0000_5063;
    localparam logic [31:0] BGEU = 32'h0000_7063;
    localparam logic [31:0] BLTU = 32'h0000_6063;

    typedef struct {
        int            due;
        logic          mp;
        logic          il;
        logic [31:0]   rd;
        logic [SW-1:0] bc;
        logic [SW-1:0] mc;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    logic [SW-1:0] m_bc = '0;
    logic [SW-1:0] m_mc = '0;
    logic [31:0]   m_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("mispredict", 32'(mispredict), 32'(e.mp));
                chk("illegal_br", 32'(illegal_br), 32'(e.il));
                chk("redirect_pc", redirect_pc, e.rd);
                chk("branch_count", 32'(branch_count), 32'(e.bc));
                chk("mispredict_count", 32'(mispredict_count), 32'(e.mc));
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pt, input logic [3:0] zsvc,
                        input logic [31:0] fpc, input int e_pred, input logic e_bt,
                        input logic e_mp, input logic [31:0] e_rd, input logic e_il);
        exp_t e;
        logic lg;
        ex_valid = v; ex_instruction = ins; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pt; fetch_pc = fpc;
        {ZFlag, SFlag, VFlag, CFlag} = zsvc;
        #1;
        if (e_pred >= 0) chk("pred_taken", 32'(pred_taken), 32'(e_pred));
        chk("branch_taken", 32'(branch_taken), 32'(e_bt));
        lg = v && ins[6:0] == 7'b1100011 && !e_il;
        if (lg && m_bc != '1) m_bc++;
        if (e_mp) begin
            m_rd = e_rd;
            if (m_mc != '1) m_mc++;
        end
        e.due = cyc + 1; e.mp = e_mp; e.il = e_il; e.rd = m_rd;
        e.bc = m_bc; e.mc = m_mc;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic [31:0] fpc, input int e_pred);
        step(1'b0, BEQ, 32'h0, 32'h0, 1'b0, 4'b1000, fpc, e_pred, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        ex_valid = 1'b1; ex_instruction = BEQ; ex_pc = 32'h100;
        ex_target = 32'h500; ex_pred_taken = 1'b0;
        {ZFlag, SFlag, VFlag, CFlag} = 4'b1000;
        rst = 1'b0;
        #1;
        chk("rst_mispredict", 32'(mispredict), 32'h0);
        chk("rst_illegal", 32'(illegal_br), 32'h0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_bcount", 32'(branch_count), 32'h0);
        chk("rst_mcount", 32'(mispredict_count), 32'h0);
        fetch_pc = 32'h0; #1;
        chk("rst_pred_0", 32'(pred_taken), 32'h0);
        fetch_pc = 32'hFC; #1;
        chk("rst_pred_fc", 32'(pred_taken), 32'h0);
        fetch_pc = 32'h100; #1;
        chk("rst_pred_100", 32'(pred_taken), 32'h0);
        q.delete();
        m_bc = '0; m_mc = '0; m_rd = '0;
        @(posedge clk); #1;
        chk("rst_hold_mp", 32'(mispredict), 32'h0);
        chk("rst_hold_bc", 32'(branch_count), 32'h0);
        chk("rst_hold_pred", 32'(pred_taken), 32'h0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset();

        // Training BEQ at 0x100, Z=1, predicted not-taken each time
        for (int i = 0; i < 3; i++)
            step(1'b1, BEQ, 32'h100, 32'h200, 1'b0, 4'b1000, 32'h100,
                 (i == 0) ? 0 : 1, 1'b1, 1'b1, 32'h200, 1'b0);
        idle(32'h100, 1);

        // Not-taken mispredict: BLTU with C=1
        step(1'b1, BLTU, 32'h40, 32'h900, 1'b1, 4'b0001, 32'h40, 0,
             1'b0, 1'b1, 32'h44, 1'b0);

        // Back-to-back mispredicts with distinct redirects
        step(1'b1, BLT, 32'h10, 32'h80, 1'b0, 4'b0100, 32'h40, 0,
             1'b1, 1'b1, 32'h80, 1'b0);
        step(1'b1, BGEU, 32'h20, 32'h700, 1'b1, 4'b0000, 32'h40, 0,
             1'b0, 1'b1, 32'h24, 1'b0);
        idle(32'h40, 0);

        // Mid-run reset, then aliasing 0x100 <-> 0x200
        do_reset();
        step(1'b1, BGE, 32'h100, 32'h300, 1'b0, 4'b0110, 32'h200, 0,
             1'b1, 1'b1, 32'h300, 1'b0);
        step(1'b1, BGE, 32'h100, 32'h300, 1'b1, 4'b0110, 32'h200, 1,
             1'b1, 1'b0, 32'h0, 1'b0);
        idle(32'h200, 1);

        // Illegal funct3 010
        step(1'b1, BILL, 32'h100, 32'h600, 1'b0, 4'b1000, 32'h100, 1,
             1'b0, 1'b0, 32'h0, 1'b1);
        idle(32'h100, 1);
        idle(32'h100, 1);

        // Branch-count saturation with 16 correctly predicted not-taken BNEs
        do_reset();
        for (int i = 0; i < 16; i++)
            step(1'b1, BNE, 32'h8, 32'h400, 1'b0, 4'b1000, 32'h8, 0,
                 1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect wrap at the top of the address space
        step(1'b1, BEQ, 32'h40, 32'h800, 1'b1, 4'b0000, 32'h8, 0,
             1'b0, 1'b1, 32'h44, 1'b0);
        step(1'b1, BEQ, 32'hFFFF_FFFC, 32'h1234, 1'b1, 4'b0000, 32'h8, 0,
             1'b0, 1'b1, 32'h0, 1'b0);
        idle(32'h8, 0);
        idle(32'h8, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/branch_predict_resolve_unit.md
# branch_predict_resolve_unit

Parametrised branch unit that replaces the purely combinational branch decision. It predicts conditional branches at fetch from a table of 2-bit saturating counters indexed by PC. It resolves them in EX from the ALU flags (Z, S, V, C), trains the table, and issues a registered one-cycle mispredict/redirect to the fetch stage and pipeline flush logic. It also keeps saturating branch and mispredict statistics counters.

## Interface
- N, 32, instruction/PC width
- BHT_DEPTH, 64, counter table entries; power of two, ≥ 2
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken)
- STAT_W, 32, width of statistics counters
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- fetch_pc  in  N  PC of the instruction being fetched
- pred_taken  out  1  prediction for fetch_pc; combinational from table state
- ex_valid  in  1  EX stage holds a valid instruction
- ex_instruction  in  N  instruction in EX
- ex_pc  in  N  PC of the instruction in EX
- ex_target  in  N  computed branch target of the EX instruction
- ex_pred_taken  in  1  prediction made at fetch, carried down the pipeline
- ZFlag, SFlag, VFlag, CFlag  in  1 each  ALU flags for the EX compare
- branch_taken  out  1  combinational resolved outcome
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  N  registered correct next PC; valid while mispredict=1
- illegal_br  out  1  registered one-cycle pulse for a branch opcode with funct3 010/011
- branch_count, mispredict_count  out  STAT_W each  saturating statistics

## Operation
- Index: IDX=$clog2(BHT_DEPTH). The index is pc[IDX+1:2]. PC bits [1:0] and the bits above IDX+1 are ignored, so aliasing is allowed.
- pred_taken = counter[idx(fetch_pc)][1].
- Branch recognised: ex_valid && ex_instruction[6:0]==7'b1100011.
- Outcome by funct3 (ex_instruction[14:12]):
  - 000 BEQ: Z
  - 001 BNE: ~Z
  - 100 BLT: S≠V
  - 101 BGE: S==V
  - 110 BLTU: ~C
  - 111 BGEU: C
  - 010/011: illegal, branch_taken=0.
- branch_taken is 0 whenever the instruction is not a recognised branch.
- On a legal branch, at the clock edge:
  - Counter at idx(ex_pc): taken → increment, saturating at 11; not-taken → decrement, saturating at 00.
  - branch_count increments, saturating at all-ones.
  - If branch_taken≠ex_pred_taken: mispredict←1, redirect_pc←(branch_taken ? ex_target : ex_pc+4), computed mod 2^N. mispredict_count increments, saturating.
  - Otherwise mispredict←0.
- On an illegal branch: illegal_br←1, no table or statistics update, mispredict←0.
- No branch in EX: mispredict←0, illegal_br←0, redirect_pc holds its value.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Only bit 1 drives the prediction.

## Timing
- Reset (asynchronous, rst=0):
  - All counters←CTR_INIT.
  - mispredict=0, illegal_br=0, redirect_pc=0, branch_count=0, mispredict_count=0.
  - Takes effect immediately, without a clock edge, including mid-operation.
  - A branch present in EX while rst=0 is discarded.
- pred_taken and branch_taken: zero-cycle latency (combinational).
- Table update is visible to pred_taken in the cycle after the resolving edge.
- Same-cycle read/write of the same index: pred_taken returns the old counter value. There is no bypass.
- mispredict/illegal_br: asserted exactly one cycle, in the cycle after resolution. Back-to-back mispredicting branches give consecutive pulses, each with its own redirect_pc.
- The unit never stalls. Flushing younger instructions is the pipeline's responsibility, using mispredict.

## Test plan
- Reset: assert rst=0 mid-run, then release. Required: pred_taken=0 for PCs 0x0 and 0xFC, all outputs zero, counters back at 01.
- Training: BEQ at ex_pc=0x100 with Z=1, ex_pred_taken=0, repeated on 3 consecutive cycles.
  - Counter goes 01→10→11→11.
  - pred_taken for fetch_pc=0x100 reads 0,1,1,1 on the cycles after the 0th, 1st, 2nd and 3rd edges respectively.
  - First branch: mispredict=1, redirect_pc=ex_target=0x200.
  - branch_count=3.
- Not-taken mispredict: BLTU at 0x40 with C=1 and ex_pred_taken=1. Required next cycle: mispredict=1, redirect_pc=0x44, mispredict_count increments.
- Aliasing: with BHT_DEPTH=64, a taken BGE (S=V=1) at 0x100 twice. Required: fetch_pc=0x200 (same index) then predicts taken.
- Illegal: opcode 1100011 with funct3=010. Required: illegal_br pulses for one cycle, branch_taken=0, counters and statistics unchanged.
- Saturation and wrap: preload branch_count near all-ones (STAT_W=4, 15 branches). Required: the 16th branch leaves the count at 15. Mispredict with ex_pc=0xFFFFFFFC and not-taken. Required: redirect_pc=0x0.
